// File: rtl/hex165_pkg.sv
// Shared types and defaults for the 74HC165 chain reader.
// Scan FSM states, default parameters and the scan-length helper.
package hex165_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int DEF_NUM_BITS    = 16;
  localparam int DEF_CLK_DIV     = 25;
  localparam int DEF_SCAN_PERIOD = 50000;

  // sys_clk cycles from LOAD entry to DONE entry
  function automatic int scan_len(input int num_bits, input int clk_div);
    return (2 * num_bits + 1) * clk_div;
  endfunction

endpackage

// File: rtl/hex165_tick.sv
// Half-period divider: tick is high on every CLK_DIV-th cycle after restart.
// Latency: restart clears the count on the next edge; no backpressure.
module hex165_tick
  import hex165_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/hex165_reader.sv
// Scans a 74HC165 chain into data; one scan is (2*NUM_BITS+1)*CLK_DIV cycles, start ignored while busy.
// Define HEX165_DEBOUNCE_EN to accept a result only when two consecutive raw scans agree.
module hex165_reader
  import hex165_pkg::*;
#(
  parameter int NUM_BITS    = DEF_NUM_BITS,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int SCAN_PERIOD = DEF_SCAN_PERIOD
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  output logic                hc_pl_n,
  output logic                hc_clk,
  input  logic                hc_ser,
  output logic [NUM_BITS-1:0] data,
  output logic                data_valid,
  output logic                changed,
  output logic                busy
);

  localparam int BCW = $clog2(NUM_BITS + 1);
  localparam int PCW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  if (NUM_BITS < 8 || NUM_BITS > 64) begin : g_bad_bits
    $error("hex165_reader: NUM_BITS must be within 8..64");
  end
  if (CLK_DIV < 4) begin : g_bad_div
    $error("hex165_reader: CLK_DIV must be at least 4");
  end

  state_t              state;
  state_t              state_nxt;
  logic                tick;
  logic                restart;
  logic                sample;
  logic                scan_end;
  logic                accept;
  logic                auto_trig;
  logic                ser_meta;
  logic                ser_sync;
  logic [BCW-1:0]      bit_cnt;
  logic [BCW-1:0]      bit_cnt_inc;
  logic [NUM_BITS-2:0] shreg;
  logic [NUM_BITS-1:0] word_nxt;

  // Free-running scan period; wraps on its own so scans keep a fixed cadence
  if (SCAN_PERIOD != 0) begin : g_auto
    localparam logic [PCW-1:0] PER_LAST = PCW'(SCAN_PERIOD - 1);
    logic [PCW-1:0] per_cnt;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        per_cnt <= '0;
      end else if (per_cnt == PER_LAST) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_cnt + PCW'(1);
      end
    end

    assign auto_trig = (per_cnt == PER_LAST);
  end else begin : g_no_auto
    assign auto_trig = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ser_meta <= 1'b0;
      ser_sync <= 1'b0;
    end else begin
      ser_meta <= hc_ser;
      ser_sync <= ser_meta;
    end
  end

  hex165_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (restart),
    .tick    (tick)
  );

  assign restart     = (state_nxt != state);
  assign bit_cnt_inc = bit_cnt + BCW'(1);
  assign word_nxt    = {shreg, ser_sync};

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || auto_trig) state_nxt = LOAD;
      end
      LOAD:   if (tick) state_nxt = SETTLE;
      SETTLE: if (tick) state_nxt = LOW;
      LOW: begin
        if (tick) begin
          sample    = 1'b1;
          state_nxt = (bit_cnt_inc < BCW'(NUM_BITS)) ? HIGH : DONE;
        end
      end
      HIGH:   if (tick) state_nxt = LOW;
      DONE: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign scan_end = sample && (bit_cnt_inc == BCW'(NUM_BITS));

  // Pin drives are registered from state_nxt so they line up with state, glitch-free
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      hc_pl_n <= 1'b1;
      hc_clk  <= 1'b0;
    end else begin
      state   <= state_nxt;
      hc_pl_n <= (state_nxt != LOAD);
      hc_clk  <= (state_nxt == HIGH);
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt_inc;
        shreg   <= word_nxt[NUM_BITS-2:0];
      end
    end
  end

`ifdef HEX165_DEBOUNCE_EN
  logic [NUM_BITS-1:0] cand;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cand <= '0;
    end else if (scan_end) begin
      cand <= word_nxt;
    end
  end

  assign accept = scan_end && (word_nxt == cand);
`else
  assign accept = scan_end;
`endif

  // Result registers load on the last sample so they are visible during DONE
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      changed    <= 1'b0;
    end else begin
      data_valid <= accept;
      changed    <= accept && (word_nxt != data);
      if (accept) data <= word_nxt;
    end
  end

endmodule

// File: tb/tb_hex165_reader.sv
// Bench for hex165_reader: on-demand instance (a) and auto-scan instance (b), each with a chain model.
// Expected results come from the word presented to the chain and the accept rule.
module tb_hex165_reader;
  import hex165_pkg::*;

  localparam int NB    = 16;
  localparam int DIV   = 25;
  localparam int PER_B = 2000;
  localparam int LEN   = (2 * NB + 1) * DIV;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          rst_a, rst_b, start_a, start_b;
  logic          pl_a, clk_a, ser_a, dv_a, ch_a, busy_a;
  logic          pl_b, clk_b, ser_b, dv_b, ch_b, busy_b;
  logic [NB-1:0] data_a, data_b;
  logic [NB-1:0] in_a, in_b, sr_a, sr_b;
  logic          clk_a_q, clk_b_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [NB-1:0] exp_w [2];
  logic [NB-1:0] cand_w [2];

  hex165_reader #(.NUM_BITS(NB), .CLK_DIV(DIV), .SCAN_PERIOD(0)) dut_a (
    .sys_clk(sys_clk), .sys_rst(rst_a), .start(start_a), .hc_pl_n(pl_a), .hc_clk(clk_a),
    .hc_ser(ser_a), .data(data_a), .data_valid(dv_a), .changed(ch_a), .busy(busy_a)
  );

  hex165_reader #(.NUM_BITS(NB), .CLK_DIV(DIV), .SCAN_PERIOD(PER_B)) dut_b (
    .sys_clk(sys_clk), .sys_rst(rst_b), .start(start_b), .hc_pl_n(pl_b), .hc_clk(clk_b),
    .hc_ser(ser_b), .data(data_b), .data_valid(dv_b), .changed(ch_b), .busy(busy_b)
  );

  // Chain behaviour: parallel load while PL# low, shift toward Q7 on CP rising edge
  always @(negedge sys_clk) begin
    if (!pl_a) sr_a = in_a;
    else if (clk_a && !clk_a_q) sr_a = sr_a << 1;
    clk_a_q = clk_a;
    if (!pl_b) sr_b = in_b;
    else if (clk_b && !clk_b_q) sr_b = sr_b << 1;
    clk_b_q = clk_b;
  end
  assign ser_a = sr_a[NB-1];
  assign ser_b = sr_b[NB-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A completed scan of raw word: accepted always, or only if equal to the previous raw scan
  task automatic model(input int u, input logic [NB-1:0] raw, output bit acc, output bit chg);
`ifdef HEX165_DEBOUNCE_EN
    acc       = (raw == cand_w[u]);
    cand_w[u] = raw;
`else
    acc = 1'b1;
`endif
    chg = acc && (raw != exp_w[u]);
    if (acc) exp_w[u] = raw;
  endtask

  task automatic scan_a(input logic [NB-1:0] val, input string tag, input bit burst);
    int   lat, pl_low, rises, extra;
    logic prev_clk;
    bit   acc, chg, done;
    in_a = val;
    model(0, val, acc, chg);
    @(negedge sys_clk) start_a = 1'b1;
    @(negedge sys_clk) start_a = 1'b0;
    lat = 0; pl_low = 0; rises = 0; extra = 0; prev_clk = 1'b0; done = 1'b0;
    while (!done && lat < 2 * LEN) begin
      if (burst && lat == 100) start_a = 1'b1;
      if (burst && lat == 110) start_a = 1'b0;
      if (!busy_a) begin
        done = 1'b1;
      end else begin
        if (!pl_a) pl_low++;
        if (clk_a && !prev_clk) rises++;
        prev_clk = clk_a;
        @(negedge sys_clk) lat++;
      end
    end
    chk({tag, "_latency"}, lat, LEN);
    chk({tag, "_pl_low"}, pl_low, DIV);
    chk({tag, "_clk_rises"}, rises, NB - 1);
    chk({tag, "_valid"}, dv_a, acc);
    chk({tag, "_changed"}, ch_a, chg);
    chk({tag, "_data"}, data_a, exp_w[0]);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (busy_a || dv_a) extra++;
    end
    chk({tag, "_no_extra"}, extra, 0);
  endtask

  task automatic run_a();
    logic [NB-1:0] v;
    int            dv_cnt;
    scan_a(16'hA5C3, "a5c3_first", 1'b0);
    scan_a(16'hA5C3, "a5c3_again", 1'b0);
    scan_a(16'h1234, "x1234_first", 1'b0);
    scan_a(16'h1234, "x1234_again", 1'b0);
    scan_a(16'hFFFF, "glitch", 1'b0);
    scan_a(16'h1234, "after_glitch", 1'b0);
    scan_a(16'h1234, "settled", 1'b0);
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      scan_a(v, "rand", 1'b0);
      if ($urandom_range(1, 0) == 1) scan_a(v, "rand_rep", 1'b0);
    end
    scan_a(16'h5A0F, "burst", 1'b1);

    // Reset in the middle of a scan
    in_a = 16'h0F0F;
    @(negedge sys_clk) start_a = 1'b1;
    @(negedge sys_clk) start_a = 1'b0;
    repeat (399) @(negedge sys_clk);
    rst_a = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid_pl_n", pl_a, 1'b1);
    chk("rst_mid_clk", clk_a, 1'b0);
    chk("rst_mid_data", data_a, '0);
    chk("rst_mid_valid", dv_a, 1'b0);
    chk("rst_mid_changed", ch_a, 1'b0);
    chk("rst_mid_busy", busy_a, 1'b0);
    rst_a     = 1'b0;
    exp_w[0]  = '0;
    cand_w[0] = '0;
    dv_cnt    = 0;
    for (int i = 0; i < LEN + 50; i++) begin
      @(negedge sys_clk);
      if (dv_a || busy_a) dv_cnt++;
    end
    chk("rst_mid_quiet", dv_cnt, 0);
    scan_a(16'hC3A5, "post_rst", 1'b0);
    scan_a(16'hC3A5, "post_rst_again", 1'b0);
  endtask

  task automatic run_b();
    int cyc, last, nscan;
    bit pb, acc, chg;
    cyc = 0; last = 0; nscan = 0; pb = 1'b0;
    while (nscan < 8 && cyc < 9 * PER_B + LEN) begin
      @(negedge sys_clk) cyc++;
      if (pb && !busy_b) begin
        model(1, in_b, acc, chg);
        chk("auto_valid", dv_b, acc);
        chk("auto_changed", ch_b, chg);
        chk("auto_data", data_b, exp_w[1]);
        if (nscan > 0) chk("auto_period", cyc - last, PER_B);
        last = cyc;
        nscan++;
`ifdef HEX165_DEBOUNCE_EN
        if (nscan % 2 == 0) in_b = (in_b == 16'h0001) ? 16'h8000 : 16'h0001;
`else
        in_b = (in_b == 16'h0001) ? 16'h8000 : 16'h0001;
`endif
      end
      pb = busy_b;
    end
    chk("auto_scan_count", nscan, 8);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    in_a = '0; in_b = 16'h0001; sr_a = '0; sr_b = '0; clk_a_q = 1'b0; clk_b_q = 1'b0;
    for (int u = 0; u < 2; u++) begin
      exp_w[u]  = '0;
      cand_w[u] = '0;
    end
    repeat (3) @(negedge sys_clk);
    chk("reset_pl_n", pl_a, 1'b1);
    chk("reset_clk", clk_a, 1'b0);
    chk("reset_data", data_a, '0);
    chk("reset_valid", dv_a, 1'b0);
    chk("reset_changed", ch_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_busy_b", busy_b, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex165_reader.md
Name: hex165_reader

Overview:
- Reads a daisy-chain of 74HC165 parallel-in/serial-out shift registers (push-buttons, DIP switches) into a parallel word.
- It is the input-side counterpart of the 74HC595 seven-segment driver: it generates the latch pulse and shift clock, and samples the serial data pin.
- Scans run free at a fixed period, or on demand from a start strobe.
- Results feed the top-level logic, for example to key UART transmissions or to load the display.

Parameters:
- NUM_BITS, 16: total bits in the chain (8 per chip); legal range 8..64.
- CLK_DIV, 25: sys_clk cycles per shift-clock half-period; minimum 4. With a 50 MHz clock the default gives a 1 MHz shift clock.
- SCAN_PERIOD, 50000: sys_clk cycles between the starts of automatic scans. 0 disables auto-scan; scans then run on start only. A non-zero value must be at least the scan length.

Ports:
- sys_clk     in   1         system clock; the only clock.
- sys_rst     in   1         synchronous, active-high reset.
- start       in   1         one-cycle request for a scan; ignored while busy.
- hc_pl_n     out  1         74HC165 PL# (parallel load), active low.
- hc_clk      out  1         74HC165 CP (shift clock).
- hc_ser      in   1         Q7 of the last chip in the chain; asynchronous.
- data        out  NUM_BITS  last accepted scan result.
- data_valid  out  1         one-cycle pulse when data updates.
- changed     out  1         one-cycle pulse, coincident with data_valid, when the new data differs from the previous data.
- busy        out  1         high from scan start until data_valid.

Behaviour:
- Reset values: hc_pl_n=1, hc_clk=0, data=0, data_valid=0, changed=0, busy=0; FSM in IDLE; period counter = 0.
- hc_ser passes through a 2-flop synchronizer. All samples use the synchronized value.
- A half-period tick fires every CLK_DIV cycles, counted from state entry.
- Scan trigger:
  - An IDLE scan starts on start=1, or when the period counter reaches SCAN_PERIOD-1 (SCAN_PERIOD≠0).
  - The period counter free-runs and wraps to 0 on an auto trigger.
  - start plus an auto trigger in the same cycle produce one scan.
- FSM states:
  - IDLE: busy=0.
  - LOAD: hc_pl_n=0 for one half-period.
  - SETTLE: hc_pl_n=1, hc_clk=0 for one half-period.
  - LOW: hc_clk=0 for one half-period. On its last cycle, sample the synchronized hc_ser into the shift register: shift left, new bit into bit 0.
  - HIGH: hc_clk=1 for one half-period, then go to LOW. HIGH is entered only while the sampled count is below NUM_BITS.
  - DONE: one cycle, then IDLE.
- Bit ordering: the first bit sampled (the last chip's D7) lands in data[NUM_BITS-1].
- Scan length: (2·NUM_BITS+1)·CLK_DIV cycles from LOAD entry to DONE entry. data and data_valid register on the DONE cycle; busy falls on that same cycle.
  - Default: 33·25 = 825 cycles.
- changed compares the new word with the old data register. The first scan after reset compares against 0.
- start during busy is dropped, not queued.
- Reset mid-scan aborts immediately to the reset values. data is cleared. No pulse is emitted.
- Bit counter width is $clog2(NUM_BITS+1). Divider width is $clog2(CLK_DIV).

Optional Feature:
- Macro: HEX165_DEBOUNCE_EN.
- Defined: a scan result is accepted only if it equals the raw result of the previous scan.
  - Otherwise the raw result is stored as a candidate, and data, data_valid and changed do not fire.
  - The candidate resets to 0.
  - A stable input therefore needs two identical consecutive scans. The first scan after reset only primes the candidate, unless the inputs are all 0.
- Undefined: every completed scan is accepted, as described above.

Decomposition:
- Package hex165_pkg:
  - FSM state enum (IDLE, LOAD, SETTLE, LOW, HIGH, DONE).
  - Default parameter constants.
  - A function that computes scan length from NUM_BITS and CLK_DIV, for the bench.
- One sub-module, hex165_tick: a CLK_DIV divider with a restart input and a tick output. It is restarted on each state entry.
- The synchronizer stays inline.

Test Plan:
- Chain model loaded with 0xA5C3; start pulse with SCAN_PERIOD=0:
  - hc_pl_n is low for 25 cycles.
  - 15 hc_clk rising edges occur.
  - data=0xA5C3, data_valid and changed pulse 825 cycles after LOAD entry.
  - busy is high across the scan.
- Same value, second start → data_valid pulses, changed=0, data unchanged.
- SCAN_PERIOD=2000, inputs toggle 0x0001↔0x8000 between scans → data_valid every 2000 cycles, changed on each; MSB/LSB ordering is correct.
- start held high for 10 cycles during a scan → exactly one scan and one data_valid.
- sys_rst asserted at cycle 400 of a scan → outputs return to reset values the next cycle, no data_valid; a following start scans cleanly.
- With HEX165_DEBOUNCE_EN, inputs 0x1234 then 0x1234 → the first scan gives no pulse; the second gives data=0x1234 with changed=1.
- With HEX165_DEBOUNCE_EN, a glitch value 0xFFFF present for one scan only → data is not updated.
